sap_controller_sequencer: RTL and testbench

- Control unit for the 8-bit CPU. It generates the strobes consumed by the program counter (cp, ep, lp) and by the MAR, RAM, IR, A, B, ALU and output registers.
- A one-hot ring counter steps through T1..T6 for each instruction. T1..T3 are the fetch cycles; T4..T6 decode the opcode supplied by the instruction register.
- The program counter registers its bus enable, so ep is issued one cycle early by default.

---
 rtl/sap_controller_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_sap_controller_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_controller_sequencer.sv
// SAP-1 control sequencer: one-hot ring counter T1..T6 with combinational opcode decode.
// Optional single-step mode is enabled by defining SAP_SEQ_STEP_EN (adds the step input).
module sap_controller_sequencer #(
  parameter bit EP_EARLY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef SAP_SEQ_STEP_EN
  input  logic       step,
`endif
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lp,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       lb,
  output logic       su,
  output logic       eu,
  output logic       lo,
  output logic       hlt,
  output logic [5:0] tstate
);

  typedef enum logic [7:0] {
    S_BOOT = 8'b0000_0001,
    S_T1   = 8'b0000_0010,
    S_T2   = 8'b0000_0100,
    S_T3   = 8'b0000_1000,
    S_T4   = 8'b0001_0000,
    S_T5   = 8'b0010_0000,
    S_T6   = 8'b0100_0000,
    S_HALT = 8'b1000_0000
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Without the early PC enable there is nothing to do in BOOT, so reset lands on T1.
  localparam state_t RESET_STATE = EP_EARLY ? S_BOOT : S_T1;

  state_t state_r;
  state_t next_s;
  logic   advance_s;
  logic   cp_s, ep_s, lp_s, lm_s, ce_s, li_s, ei_s;
  logic   la_s, ea_s, lb_s, su_s, eu_s, lo_s, hlt_s;

`ifdef SAP_SEQ_STEP_EN
  assign advance_s = step;
`else
  assign advance_s = 1'b1;
`endif

  // State register: ring counter advancing on each enabled clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RESET_STATE;
    end else if (advance_s) begin
      state_r <= next_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Next-state and raw strobe decode from state and opcode.
  always_comb begin
    next_s = state_r;
    cp_s   = 1'b0;
    ep_s   = 1'b0;
    lp_s   = 1'b0;
    lm_s   = 1'b0;
    ce_s   = 1'b0;
    li_s   = 1'b0;
    ei_s   = 1'b0;
    la_s   = 1'b0;
    ea_s   = 1'b0;
    lb_s   = 1'b0;
    su_s   = 1'b0;
    eu_s   = 1'b0;
    lo_s   = 1'b0;
    hlt_s  = 1'b0;
    case (state_r)
      S_BOOT: begin
        ep_s   = EP_EARLY;
        next_s = S_T1;
      end
      S_T1: begin
        lm_s   = 1'b1;
        ep_s   = !EP_EARLY;
        next_s = S_T2;
      end
      S_T2: begin
        cp_s   = 1'b1;
        next_s = S_T3;
      end
      S_T3: begin
        ce_s   = 1'b1;
        li_s   = 1'b1;
        next_s = S_T4;
      end
      S_T4: begin
        next_s = S_T5;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ei_s = 1'b1;
            lm_s = 1'b1;
          end
          OP_JMP: begin
            ei_s = 1'b1;
            lp_s = 1'b1;
          end
          OP_OUT: begin
            ea_s = 1'b1;
            lo_s = 1'b1;
          end
          OP_HLT: begin
            hlt_s  = 1'b1;
            next_s = S_HALT;
          end
          default: begin
            next_s = S_T5;
          end
        endcase
      end
      S_T5: begin
        next_s = S_T6;
        case (opcode)
          OP_LDA: begin
            ce_s = 1'b1;
            la_s = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ce_s = 1'b1;
            lb_s = 1'b1;
          end
          default: begin
            next_s = S_T6;
          end
        endcase
      end
      S_T6: begin
        next_s = S_T1;
        ep_s   = EP_EARLY && (opcode != OP_HLT);
        case (opcode)
          OP_ADD: begin
            eu_s = 1'b1;
            la_s = 1'b1;
          end
          OP_SUB: begin
            eu_s = 1'b1;
            su_s = 1'b1;
            la_s = 1'b1;
          end
          default: begin
            next_s = S_T1;
          end
        endcase
      end
      S_HALT: begin
        hlt_s  = 1'b1;
        next_s = S_HALT;
      end
      default: begin
        next_s = RESET_STATE;
      end
    endcase
  end

  // Reset forces every output low asynchronously; load strobes commit only on advancing clocks.
  assign cp     = rst_n & advance_s & cp_s;
  assign lp     = rst_n & advance_s & lp_s;
  assign lm     = rst_n & advance_s & lm_s;
  assign li     = rst_n & advance_s & li_s;
  assign la     = rst_n & advance_s & la_s;
  assign lb     = rst_n & advance_s & lb_s;
  assign lo     = rst_n & advance_s & lo_s;
  assign ep     = rst_n & ep_s;
  assign ce     = rst_n & ce_s;
  assign ei     = rst_n & ei_s;
  assign ea     = rst_n & ea_s;
  assign eu     = rst_n & eu_s;
  assign su     = rst_n & su_s;
  assign hlt    = rst_n & hlt_s;
  assign tstate = {6{rst_n}} & state_r[6:1];

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Randomized self-checking bench for sap_controller_sequencer against a per-T-state strobe table model.
module tb_sap_controller_sequencer;

  localparam bit EP_EARLY = 1'b1;

  localparam int B_CP = 19, B_EP = 18, B_LP = 17, B_LM = 16, B_CE = 15, B_LI = 14;
  localparam int B_EI = 13, B_LA = 12, B_EA = 11, B_LB = 10, B_SU = 9, B_EU = 8;
  localparam int B_LO = 7, B_HLT = 6;

  logic       clk;
  logic       rst_n;
  logic       step;
  logic [3:0] opcode;
  logic       cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo, hlt;
  logic [5:0] tstate;

  int n_checks = 0;
  int n_fail   = 0;

  sap_controller_sequencer #(.EP_EARLY(EP_EARLY)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef SAP_SEQ_STEP_EN
    .step(step),
`endif
    .opcode(opcode),
    .cp(cp), .ep(ep), .lp(lp), .lm(lm), .ce(ce), .li(li), .ei(ei),
    .la(la), .ea(ea), .lb(lb), .su(su), .eu(eu), .lo(lo), .hlt(hlt),
    .tstate(tstate)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [19:0] got();
    return {cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo, hlt, tstate};
  endfunction

  // Reference table: t=0 BOOT, 1..6 = T1..T6, 7 = HALT.
  function automatic logic [19:0] exp_vec(input logic [3:0] op, input int t);
    logic [19:0] v;
    v = 20'h0;
    if (t >= 1 && t <= 6) v[t-1] = 1'b1;
    case (t)
      0: v[B_EP] = EP_EARLY;
      1: begin v[B_LM] = 1'b1; v[B_EP] = !EP_EARLY; end
      2: v[B_CP] = 1'b1;
      3: begin v[B_CE] = 1'b1; v[B_LI] = 1'b1; end
      4: case (op)
           4'd0, 4'd1, 4'd2: begin v[B_EI] = 1'b1; v[B_LM] = 1'b1; end
           4'd3:  begin v[B_EI] = 1'b1; v[B_LP] = 1'b1; end
           4'd14: begin v[B_EA] = 1'b1; v[B_LO] = 1'b1; end
           4'd15: v[B_HLT] = 1'b1;
           default: ;
         endcase
      5: case (op)
           4'd0: begin v[B_CE] = 1'b1; v[B_LA] = 1'b1; end
           4'd1, 4'd2: begin v[B_CE] = 1'b1; v[B_LB] = 1'b1; end
           default: ;
         endcase
      6: begin
           v[B_EP] = EP_EARLY && (op != 4'd15);
           if (op == 4'd1 || op == 4'd2) begin v[B_EU] = 1'b1; v[B_LA] = 1'b1; end
           if (op == 4'd2) v[B_SU] = 1'b1;
         end
      7: v[B_HLT] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic restart();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in T1; T1..T3 see a random opcode to prove fetch ignores it.
  task automatic run_instr(input logic [3:0] op);
    logic [19:0] e;
    for (int t = 1; t <= 6; t++) begin
      opcode = (t >= 4) ? op : 4'($urandom);
      @(negedge clk);
      e = exp_vec(op, t);
      n_checks++;
      if (got() !== e) begin
        n_fail++;
        $display("FAIL instr op=%b T%0d: got %h expected %h", op, t, got(), e);
      end
      @(posedge clk);
      #1;
      if (op == 4'd15 && t == 4) break;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (got() !== 20'h0) begin
        n_fail++;
        $display("FAIL reset_hold: got %h expected %h", got(), 20'h0);
      end
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (got() !== exp_vec(4'd0, 0)) begin
      n_fail++;
      $display("FAIL boot: got %h expected %h", got(), exp_vec(4'd0, 0));
    end
    @(posedge clk);
    #1;
    run_instr(4'd0);
  endtask

  task automatic test_add_sub();
    restart();
    run_instr(4'd1);
    run_instr(4'd2);
    run_instr(4'd1);
  endtask

  task automatic test_jmp_out_nop();
    restart();
    run_instr(4'd3);
    run_instr(4'd14);
    run_instr(4'd5);
    run_instr(4'd3);
  endtask

  task automatic test_random();
    restart();
    for (int i = 0; i < 40; i++) run_instr(4'($urandom_range(0, 14)));
  endtask

  task automatic test_hlt();
    restart();
    run_instr(4'd1);
    run_instr(4'd15);
    for (int i = 0; i < 22; i++) begin
      opcode = 4'($urandom);
      @(negedge clk);
      n_checks++;
      if (got() !== exp_vec(4'd15, 7)) begin
        n_fail++;
        $display("FAIL halt_hold cyc=%0d: got %h expected %h", i, got(), exp_vec(4'd15, 7));
      end
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (got() !== 20'h0) begin
      n_fail++;
      $display("FAIL halt_reset: got %h expected %h", got(), 20'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (got() !== exp_vec(4'd0, 0)) begin
      n_fail++;
      $display("FAIL halt_reboot: got %h expected %h", got(), exp_vec(4'd0, 0));
    end
    @(posedge clk);
    #1;
    run_instr(4'd0);
  endtask

  task automatic test_async_reset();
    restart();
    opcode = 4'd0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_checks++;
    if (got() !== exp_vec(4'd0, 5)) begin
      n_fail++;
      $display("FAIL lda_t5: got %h expected %h", got(), exp_vec(4'd0, 5));
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (got() !== 20'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", got(), 20'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_instr(4'd2);
  endtask

`ifdef SAP_SEQ_STEP_EN
  task automatic test_step();
    logic [19:0] e;
    restart();
    @(posedge clk);
    #1;
    step = 1'b0;
    e = exp_vec(4'd0, 2);
    e[B_CP] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (got() !== e) begin
        n_fail++;
        $display("FAIL step_hold cyc=%0d: got %h expected %h", i, got(), e);
      end
      @(posedge clk);
      #1;
    end
    step = 1'b1;
    @(negedge clk);
    n_checks++;
    if (got() !== exp_vec(4'd0, 2)) begin
      n_fail++;
      $display("FAIL step_pulse: got %h expected %h", got(), exp_vec(4'd0, 2));
    end
    @(posedge clk);
    #1;
    step = 1'b0;
    e = exp_vec(4'd0, 3);
    e[B_LI] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (got() !== e) begin
      n_fail++;
      $display("FAIL step_t3: got %h expected %h", got(), e);
    end
    step = 1'b1;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    step   = 1'b1;
    opcode = 4'd0;
    test_reset();
    test_add_sub();
    test_jmp_out_nop();
    test_random();
    test_hlt();
    test_async_reset();
`ifdef SAP_SEQ_STEP_EN
    test_step();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
